l2_bus_arbiter: RTL and testbench

Shares the single L2 port among `NUM_REQ` L1 caches, one transaction at a time, with round-robin fairness. It sequences each granted transaction in order: MESI snoop broadcast, then L2 access, then response. Each L1 cache controller's `write_to_L2`/`read_from_L2` traffic becomes a bus request here. The arbiter returns the L2 block plus a shared indication, which the requester's MESI logic uses to choose EXCLUSIVE or SHARED.

---
 rtl/l2_bus_arbiter_pkg.sv | 24 ++
 rtl/l2_bus_arbiter_rr_arbiter.sv | 38 +++
 rtl/l2_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_l2_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_bus_arbiter_pkg.sv
// Shared cache-line types for the L2 bus arbiter: bus ops, arbiter states and block width.
package cacheLinePackage;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    BUS_RD  = 2'd0,
    BUS_RDX = 2'd1,
    BUS_WB  = 2'd2
  } BusOp;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SNOOP   = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } ArbState;

  // Write-backs carry their own data and never need a snoop or an L2 read.
  function automatic logic op_is_wb(input logic [1:0] op);
    return op == BUS_WB;
  endfunction

endpackage

// File: rtl/l2_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_owner_i+1 with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W:0]   cand_s;
  logic [IDX_W-1:0] idx_s;
  logic             hit_s;

  // First requester found after the previous owner wins.
  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    sum_s     = '0;
    cand_s    = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_s     = {1'b0, last_owner_i} + (IDX_W+1)'(k);
      cand_s    = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? (sum_s - (IDX_W+1)'(NUM_REQ)) : sum_s;
      idx_s     = cand_s[IDX_W-1:0];
      hit_s     = req_i[idx_s] & ~any_o;
      win_o[idx_s] = hit_s;
      win_idx_o = hit_s ? idx_s : win_idx_o;
      any_o     = any_o | hit_s;
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin owner of the single L2 port: snoop broadcast, L2 access, then response.
// Define L2_ARB_SNOOP_EN to build the SNOOP phase and snoop outputs; otherwise they are removed.
module l2_bus_arbiter
  import cacheLinePackage::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*2-1:0]        req_op,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*BLOCK_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [BLOCK_W-1:0]          rdata,
  output logic                        shared,
  output logic                        snoop_valid,
  output logic [1:0]                  snoop_op,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic [NUM_REQ-1:0]          snoop_src,
  input  logic [NUM_REQ-1:0]          snoop_hit,
  output logic                        l2_read,
  output logic                        l2_write,
  output logic [ADDR_W-1:0]           l2_addr,
  output logic [BLOCK_W-1:0]          l2_wdata,
  input  logic [BLOCK_W-1:0]          l2_rdata,
  input  logic                        l2_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ArbState              state_q, state_d;
  BusOp                 op_q, op_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BLOCK_W-1:0]   wdata_q, wdata_d;
  logic [BLOCK_W-1:0]   rdata_q, rdata_d;
  logic                 shared_q, shared_d;

  logic [1:0]           op_arr_s    [NUM_REQ];
  logic [ADDR_W-1:0]    addr_arr_s  [NUM_REQ];
  logic [BLOCK_W-1:0]   wdata_arr_s [NUM_REQ];
  logic [NUM_REQ-1:0]   win_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 any_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .win_o        (win_s),
    .win_idx_o    (win_idx_s),
    .any_o        (any_s)
  );

  // Split the flat per-requester buses so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr_s[i]    = req_op[i*2 +: 2];
      addr_arr_s[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr_s[i] = req_wdata[i*BLOCK_W +: BLOCK_W];
    end
  end

  // Next-state logic and transaction latches.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    shared_d     = shared_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          grant_d  = win_s;
          owner_d  = win_idx_s;
          op_d     = BusOp'(op_arr_s[win_idx_s]);
          addr_d   = addr_arr_s[win_idx_s];
          wdata_d  = wdata_arr_s[win_idx_s];
          shared_d = 1'b0;
`ifdef L2_ARB_SNOOP_EN
          state_d  = op_is_wb(op_arr_s[win_idx_s]) ? ACCESS : SNOOP;
`else
          state_d  = ACCESS;
`endif
        end else begin
          state_d  = IDLE;
        end
      end
`ifdef L2_ARB_SNOOP_EN
      SNOOP: begin
        // Our own copy never counts as sharing.
        shared_d = |(snoop_hit & ~grant_q);
        state_d  = ACCESS;
      end
`endif
      ACCESS: begin
        if (l2_ready) begin
          rdata_d = l2_rdata;
          state_d = RESPOND;
        end else begin
          state_d = ACCESS;
        end
      end
      RESPOND: begin
        last_owner_d = owner_q;
        grant_d      = '0;
        state_d      = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= BUS_RD;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      shared_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      shared_q     <= shared_d;
    end
  end

  assign grant = grant_q;

  // Outputs decode from registered state only, so they drop with reset at once.
  always_comb begin
    done        = '0;
    rdata       = '0;
    shared      = 1'b0;
    snoop_valid = 1'b0;
    snoop_op    = 2'b00;
    snoop_addr  = '0;
    snoop_src   = '0;
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    l2_addr     = '0;
    l2_wdata    = '0;
    case (state_q)
`ifdef L2_ARB_SNOOP_EN
      SNOOP: begin
        snoop_valid = 1'b1;
        snoop_op    = op_q;
        snoop_addr  = addr_q;
        snoop_src   = grant_q;
      end
`endif
      ACCESS: begin
        l2_addr = addr_q;
        if (op_is_wb(op_q)) begin
          l2_write = 1'b1;
          l2_wdata = wdata_q;
        end else begin
          l2_read  = 1'b1;
        end
      end
      RESPOND: begin
        done  = grant_q;
        rdata = rdata_q;
`ifdef L2_ARB_SNOOP_EN
        shared = shared_q & (op_q == BUS_RD);
`endif
      end
      default: begin
        done = '0;
      end
    endcase
  end

`ifndef L2_ARB_SNOOP_EN
  logic unused_s;
  assign unused_s = ^{snoop_hit, shared_q};
`endif

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Self-checking bench for l2_bus_arbiter: transaction-level model compared every cycle plus directed scenarios.
module tb_l2_bus_arbiter;
  import cacheLinePackage::*;

  localparam int NR = 2;
  localparam int AW = 32;
`ifdef L2_ARB_SNOOP_EN
  localparam bit SNP = 1'b1;
`else
  localparam bit SNP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*2-1:0]   req_op;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*128-1:0] req_wdata;
  logic [NR-1:0]     grant, done, snoop_src, snoop_hit;
  logic [127:0]      rdata, l2_wdata, l2_rdata;
  logic              shared, snoop_valid, l2_read, l2_write, l2_ready;
  logic [1:0]        snoop_op;
  logic [AW-1:0]     snoop_addr, l2_addr;

  l2_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata), .shared(shared),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_src(snoop_src), .snoop_hit(snoop_hit), .l2_read(l2_read), .l2_write(l2_write),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_ready(l2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  int           l2_wait = 0;
  logic [127:0] l2_data_v = '0;

  int           done_cnt = 0, snoop_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cyc = 0;
  logic [NR-1:0] done_vec = '0;
  logic [127:0] done_rdata = '0, seen_wdata = '0;
  logic         done_shared = 1'b0;
  int           order_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transaction-level model, L2 responder and per-cycle comparison.
  initial begin : model_proc
    bit           m_busy, m_snp, m_done, m_shared, found;
    int           m_owner, m_last, acc_cnt, c;
    logic [1:0]   m_op;
    logic [AW-1:0] m_addr;
    logic [127:0] m_wdata, m_rdata;
    logic [NR-1:0] eg;
    bit           e_snp, e_acc, e_done, is_wb;
    m_busy = 0; m_snp = 0; m_done = 0; m_shared = 0; m_owner = 0; m_last = NR - 1;
    acc_cnt = 0; m_op = 2'b00; m_addr = '0; m_wdata = '0; m_rdata = '0;
    l2_ready = 1'b0; l2_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 0; m_snp = 0; m_done = 0; m_shared = 0; m_last = NR - 1;
        m_rdata = '0; acc_cnt = 0; l2_ready = 1'b0; l2_rdata = '0;
      end else if (l2_read || l2_write) begin
        l2_ready = (acc_cnt == l2_wait);
        l2_rdata = l2_ready ? l2_data_v : 128'd0;
        acc_cnt  = l2_ready ? 0 : acc_cnt + 1;
      end else begin
        l2_ready = 1'b0; l2_rdata = '0; acc_cnt = 0;
      end

      eg     = m_busy ? NR'(1 << m_owner) : '0;
      is_wb  = (m_op == BUS_WB);
      e_snp  = m_busy && m_snp;
      e_done = m_busy && m_done;
      e_acc  = m_busy && !m_snp && !m_done;
      check("grant", grant, eg);
      check("done", done, e_done ? eg : '0);
      check("rdata", rdata, e_done ? m_rdata : 128'd0);
      check("shared", shared, e_done && m_shared && (m_op == BUS_RD));
      check("snoop_valid", snoop_valid, e_snp);
      check("snoop_op", snoop_op, e_snp ? m_op : 2'b00);
      check("snoop_addr", snoop_addr, e_snp ? m_addr : '0);
      check("snoop_src", snoop_src, e_snp ? eg : '0);
      check("l2_read", l2_read, e_acc && !is_wb);
      check("l2_write", l2_write, e_acc && is_wb);
      check("l2_addr", l2_addr, e_acc ? m_addr : '0);
      check("l2_wdata", l2_wdata, (e_acc && is_wb) ? m_wdata : 128'd0);
      check("rw_exclusive", l2_read & l2_write, 1'b0);

      if (!reset) begin
        if (snoop_valid) snoop_cnt++;
        if (l2_read) rd_cnt++;
        if (l2_write) begin wr_cnt++; seen_wdata = l2_wdata; end
        if (|done) begin
          done_cnt++; done_cyc = cyc; done_vec = done; done_rdata = rdata; done_shared = shared;
          order_q.push_back(done[1] ? 1 : 0);
        end
        if (m_busy) begin
          if (m_done) begin
            m_busy = 0; m_done = 0; m_last = m_owner;
          end else if (m_snp) begin
            m_shared = |(snoop_hit & ~eg);
            m_snp = 0;
          end else if (l2_ready) begin
            m_rdata = l2_rdata;
            m_done = 1;
          end
        end else begin
          found = 0;
          for (int k = 1; k <= NR; k++) begin
            c = (m_last + k) % NR;
            if (!found && req[c]) begin
              found = 1; m_owner = c;
            end
          end
          if (found) begin
            m_busy = 1; m_done = 0; m_shared = 0;
            m_op = req_op[m_owner*2 +: 2];
            m_addr = req_addr[m_owner*AW +: AW];
            m_wdata = req_wdata[m_owner*128 +: 128];
            m_snp = SNP && (m_op != BUS_WB);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [AW-1:0] a, input logic [127:0] wd);
    req_op[i*2 +: 2]     = op;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*128 +: 128] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    check("rst_grant", grant, '0);
    check("rst_done", done, '0);
    check("rst_l2_read", l2_read, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    bit ok;
    base = done_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt != base) ok = 1;
    end
    check({name, "_done_in_time"}, ok, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int c0, b_snp, b_rd, b_wr, b_done, b_ord;
    reset = 1'b1; req = '0; req_op = '0; req_addr = '0; req_wdata = '0; snoop_hit = '0;
    do_reset();

    // 1: single read from requester 0, two L2 wait cycles.
    set_req(0, BUS_RD, 32'h0000_0040, 128'd0);
    l2_wait = 2; l2_data_v = {4{32'hAAAA_AAAA}};
    b_snp = snoop_cnt; b_rd = rd_cnt;
    c0 = cyc; req = 2'b01;
    wait_done("s1", 20);
    req = '0;
    check("s1_done_vec", done_vec, 2'b01);
    check("s1_rdata", done_rdata, {4{32'hAAAA_AAAA}});
    check("s1_latency", done_cyc - c0, SNP ? 5 : 4);
    check("s1_snoops", snoop_cnt - b_snp, SNP ? 1 : 0);
    check("s1_read_cycles", rd_cnt - b_rd, 3);
    check("s1_grant_drop", grant, 2'b00);
    tick();

    // 2: both requesters held high; grants alternate starting at 0.
    do_reset();
    set_req(0, BUS_RD, 32'h0000_0100, 128'd0);
    set_req(1, BUS_RD, 32'h0000_0200, 128'd0);
    l2_wait = 0; l2_data_v = {4{32'h0F0F_0F0F}};
    b_ord = order_q.size();
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_done("s2", 20);
    req = '0;
    for (int i = 0; i < 4; i++) check($sformatf("s2_order%0d", i), order_q[b_ord + i], i % 2);
    tick();

    // 3: shared detection, then the same transfer as BUS_RDX.
    do_reset();
    snoop_hit = 2'b11;
    set_req(1, BUS_RD, 32'h0000_0080, 128'd0);
    l2_wait = 1; l2_data_v = {4{32'h5555_5555}};
    req = 2'b10;
    wait_done("s3rd", 20);
    req = '0;
    check("s3_done_vec", done_vec, 2'b10);
    check("s3_shared_rd", done_shared, SNP);
    check("s3_rdata", done_rdata, {4{32'h5555_5555}});
    tick();
    set_req(1, BUS_RDX, 32'h0000_0080, 128'd0);
    req = 2'b10;
    wait_done("s3rdx", 20);
    req = '0;
    check("s3_shared_rdx", done_shared, 1'b0);
    snoop_hit = '0;
    tick();

    // 4: write-back from requester 1 skips the snoop.
    do_reset();
    set_req(1, BUS_WB, 32'h0000_0C00, {4{32'h1234_5678}});
    l2_wait = 1;
    b_snp = snoop_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
    c0 = cyc; req = 2'b10;
    wait_done("s4", 20);
    req = '0;
    check("s4_done_vec", done_vec, 2'b10);
    check("s4_snoops", snoop_cnt - b_snp, 0);
    check("s4_reads", rd_cnt - b_rd, 0);
    check("s4_writes", wr_cnt - b_wr, 2);
    check("s4_wdata", seen_wdata, {4{32'h1234_5678}});
    check("s4_latency", done_cyc - c0, 3);
    tick();

    // 5: reset while l2_read is high aborts without done; requester 0 wins afterwards.
    do_reset();
    set_req(0, BUS_RD, 32'h0000_0040, 128'd0);
    set_req(1, BUS_RD, 32'h0000_0300, 128'd0);
    l2_wait = 6; l2_data_v = {4{32'hC3C3_C3C3}};
    req = 2'b01;
    for (int i = 0; i < 10 && !l2_read; i++) tick();
    check("s5_read_seen", l2_read, 1'b1);
    b_done = done_cnt;
    reset = 1'b1;
    #1;
    check("s5_rst_grant", grant, 2'b00);
    check("s5_rst_l2_read", l2_read, 1'b0);
    check("s5_rst_l2_addr", l2_addr, 32'h0);
    check("s5_rst_done", done, 2'b00);
    tick();
    tick();
    check("s5_no_done", done_cnt - b_done, 0);
    reset = 1'b0;
    req = 2'b11;
    l2_wait = 0;
    wait_done("s5", 20);
    req = '0;
    check("s5_first_owner", done_vec, 2'b01);
    check("s5_done_count", done_cnt - b_done, 1);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
